// File: rtl/fc_pkg.sv
// Shared types and constants for the fully-connected layer accumulator.
// Holds the controller state encoding, the weight-memory address width,
// the parked (out-of-range) address rule and the minimum accumulator width.
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int ADDR_WIDTH = 8;

    // Address driven whenever no row is being requested; one past the last
    // row, so the weight memory answers with zeros.
    function automatic logic [ADDR_WIDTH-1:0] idle_addr(input int nodes);
        return ADDR_WIDTH'(nodes);
    endfunction

    // Smallest accumulator that cannot overflow for full-scale operands.
    function automatic int min_acc_width(input int data_width, input int nodes);
        return 2 * data_width + $clog2(nodes);
    endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One output node of the fully-connected layer: signed multiply of the
// returned weight by the current activation, accumulated with wrap-around.
// Build option FC_ACC_RELU_EN clamps negative results to zero at the output.
module fc_mac_lane
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] weight,
    input  logic [DATA_WIDTH-1:0] act,
    output logic [ACC_WIDTH-1:0]  result
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    acc_p2;

`ifdef FC_ACC_RELU_EN
    function automatic logic signed [ACC_WIDTH-1:0] relu(input logic signed [ACC_WIDTH-1:0] v);
        return v[ACC_WIDTH-1] ? '0 : v;
    endfunction
`endif

    assign prod = $signed(weight) * $signed(act);

    // --- stage 2: accumulate the sign-extended product (wraps at ACC_WIDTH) ---
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p2 <= '0;
        end else if (clr) begin
            acc_p2 <= '0;
        end else if (en) begin
            acc_p2 <= acc_p2 + ACC_WIDTH'(prod);
        end
    end

`ifdef FC_ACC_RELU_EN
    assign result = relu(acc_p2);
`else
    assign result = acc_p2;
`endif

endmodule

// File: rtl/fc_layer_accumulator.sv
// Fully-connected layer accumulator: latches an activation vector, sweeps
// weight-memory rows 0..INPUT_NODES-1, accumulates OUTPUT_NODES lanes and
// hands the result vector downstream with valid/ready.
// Build option FC_ACC_RELU_EN enables a ReLU on the result lanes.
module fc_layer_accumulator
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int INPUT_NODES  = 24,
    parameter int OUTPUT_NODES = 128,
    parameter int ACC_WIDTH    = 24
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH*INPUT_NODES-1:0] in_data,
    output logic [ADDR_WIDTH-1:0]             address,
    input  logic [DATA_WIDTH*OUTPUT_NODES-1:0] weights,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ACC_WIDTH*OUTPUT_NODES-1:0] out_data
);

    localparam logic [ADDR_WIDTH-1:0] IDLE_ADDR = idle_addr(INPUT_NODES);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW  = ADDR_WIDTH'(INPUT_NODES - 1);

    if (ACC_WIDTH < min_acc_width(DATA_WIDTH, INPUT_NODES)) begin : g_acc_width_check
        $error("ACC_WIDTH too small for DATA_WIDTH/INPUT_NODES");
    end

    state_t                           state, state_next;
    logic [ADDR_WIDTH-1:0]            cnt;
    logic [DATA_WIDTH*INPUT_NODES-1:0] act_vec;
    logic                             accept;
    logic                             vld_p1;
    logic [ADDR_WIDTH-1:0]            k_p1;
    logic [DATA_WIDTH-1:0]            act_sel;
    logic [ACC_WIDTH-1:0]             lane_res [OUTPUT_NODES];

    assign accept    = (state == IDLE) && in_valid;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)        state_next = RUN;
            RUN:     if (cnt == LAST_ROW) state_next = DRAIN;
            DRAIN:                        state_next = DONE;
            DONE:    if (out_ready)       state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    // Row counter: cleared on accept, advanced once per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (state == RUN) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Address comes from registered state/counter only.
    always_comb begin
        address = (state == RUN) ? cnt : IDLE_ADDR;
    end

    // Activation vector capture on the accepting handshake.
    always_ff @(posedge clk) begin
        if (accept) begin
            act_vec <= in_data;
        end
    end

    // --- stage 1: row index/valid delayed to match the weight-memory latency ---
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            k_p1   <= '0;
        end else begin
            vld_p1 <= (state == RUN);
            k_p1   <= cnt;
        end
    end

    // Pick the activation belonging to the row now arriving from memory.
    always_comb begin
        act_sel = '0;
        for (int k = 0; k < INPUT_NODES; k++) begin
            if (k_p1 == ADDR_WIDTH'(k)) begin
                act_sel = act_vec[(INPUT_NODES-1-k)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    for (genvar j = 0; j < OUTPUT_NODES; j++) begin : g_lane
        fc_mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (accept),
            .en     (vld_p1),
            .weight (weights[(OUTPUT_NODES-1-j)*DATA_WIDTH +: DATA_WIDTH]),
            .act    (act_sel),
            .result (lane_res[j])
        );

        assign out_data[(OUTPUT_NODES-1-j)*ACC_WIDTH +: ACC_WIDTH] = out_valid ? lane_res[j] : '0;
    end

endmodule

// File: tb/tb_fc_layer_accumulator.sv
// Directed testbench for fc_layer_accumulator with a registered weight-memory
// model (one-cycle read latency, zeros for out-of-range rows).
module tb_fc_layer_accumulator;

    localparam int DW = 8;
    localparam int NI = 24;
    localparam int NO = 128;
    localparam int AW = 24;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [DW*NI-1:0]   in_data = '0;
    logic [7:0]         address;
    logic [DW*NO-1:0]   weights = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [AW*NO-1:0]   out_data;

    int errors = 0;
    int checks = 0;
    int mode   = 0;

    fc_layer_accumulator #(
        .DATA_WIDTH   (DW),
        .INPUT_NODES  (NI),
        .OUTPUT_NODES (NO),
        .ACC_WIDTH    (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .address   (address),
        .weights   (weights),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Weight-memory row content for the current test mode.
    function automatic logic [DW*NO-1:0] mem_row(input int a, input int m);
        logic [DW*NO-1:0] r;
        logic [7:0]       w;
        r = '0;
        if (a < NI) begin
            for (int j = 0; j < NO; j++) begin
                case (m)
                    0:       w = 8'h01;
                    1:       w = 8'hFF;
                    2:       w = 8'(a);
                    default: w = (j == 0) ? 8'h80 : 8'(a);
                endcase
                r[(NO-1-j)*DW +: DW] = w;
            end
        end
        return r;
    endfunction

    always @(posedge clk) weights <= mem_row(int'(address), mode);

    function automatic logic [DW*NI-1:0] fill(input logic [7:0] v);
        logic [DW*NI-1:0] r;
        for (int k = 0; k < NI; k++) r[k*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [AW-1:0] lane(input int j);
        return out_data[(NO-1-j)*AW +: AW];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", tag, got, got, exp, exp);
        end
    endtask

    // Lane 0 and lane 127 individually, then the count of other lanes that differ.
    task automatic check_lanes(input string tag, input logic [AW-1:0] exp0, input logic [AW-1:0] exp_rest);
        int bad;
        bad = 0;
        check({tag, "_lane0"}, {8'h0, lane(0)}, {8'h0, exp0});
        check({tag, "_lane127"}, {8'h0, lane(NO-1)}, {8'h0, exp_rest});
        for (int j = 1; j < NO; j++) if (lane(j) !== exp_rest) bad++;
        check({tag, "_bad_lanes"}, bad, 0);
    endtask

    // Offer a vector, follow the job until out_valid, checking latency and address order.
    task automatic do_job(input string tag, input logic [DW*NI-1:0] vec);
        int lat, addr_err, busy_err;
        logic [7:0] exp_addr;
        @(negedge clk);
        check({tag, "_in_ready_idle"}, in_ready, 1);
        in_data  = vec;
        in_valid = 1'b1;
        lat = 0; addr_err = 0; busy_err = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == 1) in_valid = 1'b0;
            exp_addr = (lat <= NI) ? 8'(lat - 1) : 8'(NI);
            if (address !== exp_addr) addr_err++;
            if (in_ready !== 1'b0) busy_err++;
            if (out_valid === 1'b1) break;
        end
        check({tag, "_latency"}, lat, 26);
        check({tag, "_addr_seq"}, addr_err, 0);
        check({tag, "_in_ready_busy"}, busy_err, 0);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_out_valid_after"}, out_valid, 0);
        check({tag, "_in_ready_after"}, in_ready, 1);
    endtask

    initial begin
        logic [AW*NO-1:0] snap;
        int unstable, n;

        // Reset values
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_address", address, 24);
        check("rst_out_lane0", {8'h0, lane(0)}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // All weights 1, activations 2 -> 48
        mode = 0;
        do_job("ones", fill(8'h02));
        check_lanes("ones", 24'd48, 24'd48);
        @(negedge clk);
        release_out("ones");

        // Weights -1, activations 127 -> -3048 (ReLU -> 0)
        mode = 1;
        do_job("neg", fill(8'h7F));
`ifdef FC_ACC_RELU_EN
        check_lanes("neg", 24'h000000, 24'h000000);
`else
        check_lanes("neg", 24'hFFF418, 24'hFFF418);
`endif
        @(negedge clk);
        release_out("neg");

        // Row k weights = k, activations 1 -> 276; then hold in DONE
        mode = 2;
        do_job("ramp", fill(8'h01));
        check_lanes("ramp", 24'd276, 24'd276);
        snap = out_data;
        unstable = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = c[0];
            in_data  = fill(8'(c + 5));
            if (out_data !== snap || out_valid !== 1'b1 || in_ready !== 1'b0) unstable++;
        end
        in_valid = 1'b0;
        check("hold_unstable_cycles", unstable, 0);
        check("hold_out_valid", out_valid, 1);
        @(negedge clk);
        release_out("hold");

        // Lane 0 weights 0x80, activations 0x80 -> 393216; other lanes 276*-128
        mode = 3;
        do_job("minval", fill(8'h80));
`ifdef FC_ACC_RELU_EN
        check_lanes("minval", 24'd393216, 24'h000000);
`else
        check_lanes("minval", 24'd393216, 24'hFF7600);
`endif
        @(negedge clk);
        release_out("minval");

        // Reset in the middle of a job while address = 10
        mode = 2;
        @(negedge clk);
        in_data  = fill(8'h03);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (address !== 8'd10 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("midrst_reached_addr10", address, 10);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_lane0", {8'h0, lane(0)}, 0);
        check("midrst_address", address, 24);
        check("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        do_job("postrst", fill(8'h01));
        check_lanes("postrst", 24'd276, 24'd276);
        @(negedge clk);
        release_out("postrst");

        // Back-to-back jobs with out_ready held high
        @(negedge clk);
        out_ready = 1'b1;
        in_data   = fill(8'h01);
        in_valid  = 1'b1;
        @(negedge clk);
        in_data = fill(8'h02);
        n = 1;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_latency", n, 26);
        check_lanes("b2b_first", 24'd276, 24'd276);
        @(negedge clk);
        check("b2b_gap_in_ready", in_ready, 1);
        check("b2b_gap_out_valid", out_valid, 0);
        @(negedge clk);
        check("b2b_second_accepted", in_ready, 0);
        in_valid = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("b2b_second_latency", n, 26);
        check_lanes("b2b_second", 24'd552, 24'd552);
        @(negedge clk);
        check("b2b_end_out_valid", out_valid, 0);
        out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
